// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move controller.
// Cell k of the 3x3 board maps to bit k, row-major from the top-left corner.
package ttt_pkg;

  typedef enum logic [2:0] {
    WAIT_MOVE,
    VALIDATE,
    COMMIT,
    CHECK,
    DONE
  } state_e;

  localparam int NUM_CELLS = 9;

  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Index 0..2 rows, 3..5 columns, 6..7 diagonals.
  localparam logic [7:0][NUM_CELLS-1:0] WIN_LINES = {
    9'h054, 9'h111,
    9'h124, 9'h092, 9'h049,
    9'h1C0, 9'h038, 9'h007
  };

endpackage

// File: rtl/ttt_win_check.sv
// Combinational three-in-a-row detector for a single player's board.
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [NUM_CELLS-1:0] board_i,
  output logic                 win_o
);

  always_comb begin
    win_o = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if ((board_i & WIN_LINES[l]) == WIN_LINES[l]) begin
        win_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttt_move_controller.sv
// Game sequencer: accepts moves by handshake, validates, commits them to the
// boards and reports win or draw. All outputs are registered except move_ready.
module ttt_move_controller
  import ttt_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0,
  parameter logic ALT_START    = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic        move_player,
  input  logic [3:0]  move_pos,
  output logic        move_ready,
  output logic [15:0] pos_en,
  output logic [8:0]  x_board,
  output logic [8:0]  o_board,
  output logic        turn,
  output logic        illegal,
  output logic        game_over,
  output logic [1:0]  winner
);

  state_e               state_q, state_d;
  logic                 movePlayer_q, movePlayer_d;
  logic [3:0]           movePos_q, movePos_d;
  logic [NUM_CELLS-1:0] xBoard_q, xBoard_d;
  logic [NUM_CELLS-1:0] oBoard_q, oBoard_d;
  logic                 turn_q, turn_d;
  logic                 start_q, start_d;
  logic                 illegal_q, illegal_d;
  logic                 gameOver_q, gameOver_d;
  logic [1:0]           winner_q, winner_d;
  logic [15:0]          posEn_q, posEn_d;

  logic [15:0]          posOneHot;
  logic                 occupied;
  logic                 moveIllegal;
  logic                 boardFull;
  logic                 lineWin;
  logic                 accept;
  logic [NUM_CELLS-1:0] checkBoard;

  // The one-hot form doubles as an occupancy mask; positions 9..15 land outside the board bits.
  assign posOneHot   = 16'd1 << movePos_q;
  assign occupied    = |(posOneHot[NUM_CELLS-1:0] & (xBoard_q | oBoard_q));
  assign moveIllegal = (movePlayer_q != turn_q) || (movePos_q > 4'd8) || occupied;
  assign boardFull   = &(xBoard_q | oBoard_q);
  assign accept      = move_valid & move_ready & ~new_game;
  assign checkBoard  = (turn_q == PLAYER_O) ? oBoard_q : xBoard_q;

  ttt_win_check u_winCheck (
    .board_i (checkBoard),
    .win_o   (lineWin)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WAIT_MOVE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = WAIT_MOVE;
    end else begin
      case (state_q)
        WAIT_MOVE: if (accept) state_d = VALIDATE;
        VALIDATE:  state_d = moveIllegal ? WAIT_MOVE : COMMIT;
        COMMIT:    state_d = CHECK;
        CHECK:     state_d = (lineWin || boardFull) ? DONE : WAIT_MOVE;
        DONE:      state_d = DONE;
        default:   state_d = WAIT_MOVE;
      endcase
    end
  end

  always_comb begin
    move_ready   = (state_q == WAIT_MOVE);
    movePlayer_d = movePlayer_q;
    movePos_d    = movePos_q;
    xBoard_d     = xBoard_q;
    oBoard_d     = oBoard_q;
    turn_d       = turn_q;
    start_d      = start_q;
    illegal_d    = 1'b0;
    gameOver_d   = gameOver_q;
    winner_d     = winner_q;
    posEn_d      = 16'd0;
    if (new_game) begin
      start_d    = ALT_START ? ~start_q : start_q;
      turn_d     = start_d;
      xBoard_d   = '0;
      oBoard_d   = '0;
      gameOver_d = 1'b0;
      winner_d   = WIN_NONE;
    end else begin
      case (state_q)
        WAIT_MOVE: begin
          if (accept) begin
            movePlayer_d = move_player;
            movePos_d    = move_pos;
          end
        end
        VALIDATE: illegal_d = moveIllegal;
        COMMIT: begin
          posEn_d = posOneHot;
          if (turn_q == PLAYER_O) begin
            oBoard_d = oBoard_q | posOneHot[NUM_CELLS-1:0];
          end else begin
            xBoard_d = xBoard_q | posOneHot[NUM_CELLS-1:0];
          end
        end
        CHECK: begin
          // A completed line on the ninth cell must win over the full-board draw.
          if (lineWin) begin
            winner_d   = (turn_q == PLAYER_O) ? WIN_O : WIN_X;
            gameOver_d = 1'b1;
          end else if (boardFull) begin
            winner_d   = WIN_DRAW;
            gameOver_d = 1'b1;
          end else begin
            turn_d = ~turn_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      movePlayer_q <= 1'b0;
      movePos_q    <= 4'd0;
      xBoard_q     <= '0;
      oBoard_q     <= '0;
      turn_q       <= FIRST_PLAYER;
      start_q      <= FIRST_PLAYER;
      illegal_q    <= 1'b0;
      gameOver_q   <= 1'b0;
      winner_q     <= WIN_NONE;
      posEn_q      <= 16'd0;
    end else begin
      movePlayer_q <= movePlayer_d;
      movePos_q    <= movePos_d;
      xBoard_q     <= xBoard_d;
      oBoard_q     <= oBoard_d;
      turn_q       <= turn_d;
      start_q      <= start_d;
      illegal_q    <= illegal_d;
      gameOver_q   <= gameOver_d;
      winner_q     <= winner_d;
      posEn_q      <= posEn_d;
    end
  end

  assign pos_en    = posEn_q;
  assign x_board   = xBoard_q;
  assign o_board   = oBoard_q;
  assign turn      = turn_q;
  assign illegal   = illegal_q;
  assign game_over = gameOver_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_ttt_move_controller.sv
// Scoreboard bench for ttt_move_controller: stimulus queues expected illegal,
// commit and end-of-game events; a negedge monitor pops and compares them.
module tb_ttt_move_controller;

  localparam int EV_ILLEGAL = 0;
  localparam int EV_COMMIT  = 1;
  localparam int EV_END     = 2;

  typedef struct {
    int          kind;
    logic [15:0] posEn;
    logic [8:0]  xB;
    logic [8:0]  oB;
    logic        t;
    logic [1:0]  w;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        new_game = 1'b0;
  logic        move_valid = 1'b0;
  logic        move_player = 1'b0;
  logic [3:0]  move_pos = 4'd0;
  logic        move_ready;
  logic [15:0] pos_en;
  logic [8:0]  x_board;
  logic [8:0]  o_board;
  logic        turn;
  logic        illegal;
  logic        game_over;
  logic [1:0]  winner;

  int   total = 0;
  int   bad   = 0;
  exp_t expQ[$];
  logic goPrev = 1'b0;

  ttt_move_controller #(
    .FIRST_PLAYER (1'b0),
    .ALT_START    (1'b1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .new_game    (new_game),
    .move_valid  (move_valid),
    .move_player (move_player),
    .move_pos    (move_pos),
    .move_ready  (move_ready),
    .pos_en      (pos_en),
    .x_board     (x_board),
    .o_board     (o_board),
    .turn        (turn),
    .illegal     (illegal),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clock = ~clock;

  task automatic pushExp(input int kind, input logic [15:0] pe, input logic [8:0] xb,
                         input logic [8:0] ob, input logic t, input logic [1:0] w);
    exp_t e;
    e.kind = kind; e.posEn = pe; e.xB = xb; e.oB = ob; e.t = t; e.w = w;
    expQ.push_back(e);
  endtask

  task automatic popCompare(input int kind);
    exp_t e;
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_event: got kind=%0d pos_en=%h x=%h o=%h turn=%0d winner=%0d, expected no event",
               kind, pos_en, x_board, o_board, turn, winner);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.posEn != pos_en || e.xB != x_board || e.oB != o_board ||
          e.t != turn || e.w != winner) begin
        bad++;
        $display("[TB] FAIL event: got kind=%0d pos_en=%h x=%h o=%h turn=%0d winner=%0d, expected kind=%0d pos_en=%h x=%h o=%h turn=%0d winner=%0d",
                 kind, pos_en, x_board, o_board, turn, winner,
                 e.kind, e.posEn, e.xB, e.oB, e.t, e.w);
      end
    end
  endtask

  // Monitor: any illegal pulse, commit strobe or game_over rise must match the queue head.
  always @(negedge clock) begin
    if (!reset) begin
      if (illegal) popCompare(EV_ILLEGAL);
      if (pos_en != 16'd0) popCompare(EV_COMMIT);
      if (game_over && !goPrev) popCompare(EV_END);
    end
    goPrev = game_over;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitIdle();
    bit done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      if (move_ready || game_over) done = 1;
      else begin
        @(posedge clock);
        #1;
      end
    end
    if (!done) checkOutput("idle_timeout", 16'd0, 16'd1);
  endtask

  task automatic applyStimulus(input logic p, input logic [3:0] pos);
    @(negedge clock);
    move_valid  = 1'b1;
    move_player = p;
    move_pos    = pos;
    @(posedge clock);
    #1;
    move_valid = 1'b0;
    waitIdle();
  endtask

  task automatic pulseNewGame();
    @(negedge clock);
    new_game = 1'b1;
    @(posedge clock);
    #1;
    new_game = 1'b0;
  endtask

  task automatic legalMove(input logic p, input logic [3:0] pos, input logic [8:0] xb, input logic [8:0] ob);
    pushExp(EV_COMMIT, 16'd1 << pos, xb, ob, p, 2'b00);
    applyStimulus(p, pos);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    checkOutput("rst_ready", 16'(move_ready), 16'd1);
    checkOutput("rst_pos_en", pos_en, 16'd0);
    checkOutput("rst_x", 16'(x_board), 16'd0);
    checkOutput("rst_o", 16'(o_board), 16'd0);
    checkOutput("rst_turn", 16'(turn), 16'd0);
    checkOutput("rst_illegal", 16'(illegal), 16'd0);
    checkOutput("rst_game_over", 16'(game_over), 16'd0);
    checkOutput("rst_winner", 16'(winner), 16'd0);

    // Wrong player
    pushExp(EV_ILLEGAL, 16'd0, 9'h000, 9'h000, 1'b0, 2'b00);
    applyStimulus(1'b1, 4'd5);
    checkOutput("wrong_player_turn", 16'(turn), 16'd0);

    // Occupied cell then out-of-range cell
    legalMove(1'b0, 4'd4, 9'h010, 9'h000);
    checkOutput("turn_after_x", 16'(turn), 16'd1);
    pushExp(EV_ILLEGAL, 16'd0, 9'h010, 9'h000, 1'b1, 2'b00);
    applyStimulus(1'b1, 4'd4);
    pushExp(EV_ILLEGAL, 16'd0, 9'h010, 9'h000, 1'b1, 2'b00);
    applyStimulus(1'b1, 4'd12);
    checkOutput("illegal_turn_kept", 16'(turn), 16'd1);
    checkOutput("illegal_x_kept", 16'(x_board), 16'h010);

    // Start player alternation: 0 -> 1 -> 0
    pulseNewGame();
    checkOutput("ng1_turn", 16'(turn), 16'd1);
    checkOutput("ng1_x", 16'(x_board), 16'd0);
    pulseNewGame();
    checkOutput("ng2_turn", 16'(turn), 16'd0);

    // X wins on the top row
    legalMove(1'b0, 4'd0, 9'h001, 9'h000);
    legalMove(1'b1, 4'd3, 9'h001, 9'h008);
    legalMove(1'b0, 4'd1, 9'h003, 9'h008);
    legalMove(1'b1, 4'd4, 9'h003, 9'h018);
    pushExp(EV_COMMIT, 16'h0004, 9'h007, 9'h018, 1'b0, 2'b00);
    pushExp(EV_END, 16'd0, 9'h007, 9'h018, 1'b0, 2'b01);
    applyStimulus(1'b0, 4'd2);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("win_winner", 16'(winner), 16'h1);
    checkOutput("win_game_over", 16'(game_over), 16'd1);
    checkOutput("win_ready", 16'(move_ready), 16'd0);

    // new_game from DONE
    pulseNewGame();
    checkOutput("ng3_x", 16'(x_board), 16'd0);
    checkOutput("ng3_o", 16'(o_board), 16'd0);
    checkOutput("ng3_winner", 16'(winner), 16'd0);
    checkOutput("ng3_game_over", 16'(game_over), 16'd0);
    checkOutput("ng3_turn", 16'(turn), 16'd1);
    pulseNewGame();
    checkOutput("ng4_turn", 16'(turn), 16'd0);

    // Draw
    legalMove(1'b0, 4'd0, 9'h001, 9'h000);
    legalMove(1'b1, 4'd1, 9'h001, 9'h002);
    legalMove(1'b0, 4'd2, 9'h005, 9'h002);
    legalMove(1'b1, 4'd4, 9'h005, 9'h012);
    legalMove(1'b0, 4'd3, 9'h00D, 9'h012);
    legalMove(1'b1, 4'd5, 9'h00D, 9'h032);
    legalMove(1'b0, 4'd7, 9'h08D, 9'h032);
    legalMove(1'b1, 4'd6, 9'h08D, 9'h072);
    pushExp(EV_COMMIT, 16'h0100, 9'h18D, 9'h072, 1'b0, 2'b00);
    pushExp(EV_END, 16'd0, 9'h18D, 9'h072, 1'b0, 2'b11);
    applyStimulus(1'b0, 4'd8);
    @(posedge clock);
    #1;
    checkOutput("draw_winner", 16'(winner), 16'h3);

    // Requests in DONE are ignored
    @(negedge clock);
    move_valid  = 1'b1;
    move_player = 1'b1;
    move_pos    = 4'd9;
    repeat (4) @(posedge clock);
    #1;
    move_valid = 1'b0;
    checkOutput("done_x", 16'(x_board), 16'h18D);
    checkOutput("done_o", 16'(o_board), 16'h072);
    checkOutput("done_game_over", 16'(game_over), 16'd1);

    // Reset during COMMIT aborts the move
    pulseNewGame();
    checkOutput("ng5_turn", 16'(turn), 16'd1);
    @(negedge clock);
    move_valid  = 1'b1;
    move_player = 1'b1;
    move_pos    = 4'd0;
    @(posedge clock);
    #1;
    move_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("abort_pos_en", pos_en, 16'd0);
    checkOutput("abort_o", 16'(o_board), 16'd0);
    checkOutput("abort_turn", 16'(turn), 16'd0);
    checkOutput("abort_ready", 16'(move_ready), 16'd1);
    checkOutput("abort_winner", 16'(winner), 16'd0);

    // new_game together with move_valid: move not taken
    @(negedge clock);
    new_game    = 1'b1;
    move_valid  = 1'b1;
    move_player = 1'b1;
    move_pos    = 4'd0;
    @(posedge clock);
    #1;
    new_game   = 1'b0;
    move_valid = 1'b0;
    checkOutput("ngmv_ready", 16'(move_ready), 16'd1);
    checkOutput("ngmv_turn", 16'(turn), 16'd1);
    repeat (4) @(posedge clock);
    #1;
    checkOutput("ngmv_o", 16'(o_board), 16'd0);

    repeat (3) @(posedge clock);
    #1;
    checkOutput("queue_drained", 16'(expQ.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ttt_move_controller.md
Name: ttt_move_controller

Overview:
- Sequences a two-player tic-tac-toe game on the 3x3 board; sits between the player input logic and the board/display datapath.
- Accepts move requests through a valid/ready handshake and enforces turn order.
- Rejects illegal or occupied positions, commits legal moves, drives a one-hot cell write strobe, and detects win or draw.

Parameters:
- FIRST_PLAYER, 1'b0, player that moves first after reset (0 = X, 1 = O).
- ALT_START, 1'b1, if 1 the first mover alternates on each new_game; if 0 it is always FIRST_PLAYER.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- new_game  in  1  single-cycle pulse: clear board, start a new game
- move_valid  in  1  move request present
- move_player  in  1  requesting player (0 = X, 1 = O)
- move_pos  in  4  requested cell 0..8; 9..15 illegal
- move_ready  out  1  controller can accept a move
- pos_en  out  16  one-hot cell write strobe, bit k = cell k, high one cycle on commit
- x_board  out  9  cells held by X
- o_board  out  9  cells held by O
- turn  out  1  player to move
- illegal  out  1  one-cycle pulse on a rejected move
- game_over  out  1  high while the game has ended
- winner  out  2  00 none, 01 X, 10 O, 11 draw

Behaviour:
- Reset values:
  - state = WAIT_MOVE, move_ready = 1
  - pos_en = 0, x_board = 0, o_board = 0
  - turn = FIRST_PLAYER
  - illegal = 0, game_over = 0, winner = 00
  - start-player register = FIRST_PLAYER
- WAIT_MOVE: move_ready = 1. A handshake (move_valid & move_ready) captures move_player and move_pos, then -> VALIDATE. move_ready is 0 in every other state.
- VALIDATE (one cycle): the move is illegal if move_player != turn, move_pos > 8, or the cell is set in x_board | o_board.
  - Illegal: illegal = 1 for this cycle, registered output visible on the next edge; -> WAIT_MOVE. Board and turn unchanged.
  - Legal: -> COMMIT.
- COMMIT (one cycle): set the cell bit in the mover's board; pos_en = one-hot(pos) for exactly this cycle; -> CHECK.
- CHECK (one cycle): test the 8 win lines (3 rows, 3 columns, 2 diagonals) on the mover's updated board.
  - Win: winner = mover (01 or 10), game_over = 1, -> DONE.
  - Else, if (x_board | o_board) == 9'h1FF: winner = 11, game_over = 1, -> DONE.
  - Else: toggle turn, -> WAIT_MOVE.
- DONE: hold boards, winner and game_over. move_valid is ignored and never produces illegal.
- Latency, with the handshake at edge N:
  - illegal asserted cycle N+1
  - pos_en and board update visible after edge N+2
  - turn toggle or game_over visible after edge N+3
  - next move_ready = 1 at N+3
- new_game, accepted in any state, takes priority over everything except reset:
  - clears the boards, winner, game_over, illegal and pos_en
  - if ALT_START, toggles the start-player register first
  - sets turn = start-player and state = WAIT_MOVE
  - a move_valid in the same cycle is not accepted
- Reset asserted mid-sequence (VALIDATE, COMMIT or CHECK) aborts the move; no pos_en pulse is issued.
- A win on the ninth cell reports the player, not a draw.
- move_pos 9..15 never produces a pos_en pulse.

Decomposition:
- Package ttt_pkg:
  - state enum {WAIT_MOVE, VALIDATE, COMMIT, CHECK, DONE}
  - PLAYER_X/PLAYER_O constants
  - WIN_NONE/WIN_X/WIN_O/WIN_DRAW constants
  - WIN_LINES, an 8 x 9-bit mask array
  - NUM_CELLS = 9
- Sub-module ttt_win_check: combinational, 9-bit board in, 1-bit win out, OR over the 8 masked-AND lines. Instantiated once on the mover's board.

Test Plan:
- X plays 0, O plays 3, X plays 1, O plays 4, X plays 2 -> pos_en = 16'h0004 on the last commit; winner = 01, game_over = 1; x_board = 9'h007, o_board = 9'h018.
- With turn = X, O requests pos 5 -> illegal pulses 1 cycle; boards unchanged; turn stays 0.
- Request an occupied cell, then pos 12 -> illegal both times; pos_en stays 0; turn unchanged.
- Nine-move sequence with no line (X:0,2,3,7,8; O:1,4,5,6) -> winner = 11 after the last CHECK; move_valid in DONE ignored.
- new_game pulse during DONE with ALT_START = 1 -> boards 0, winner 00, turn = 1; next new_game gives turn = 0.
- reset asserted in the COMMIT cycle -> no board bit set, all outputs at reset values the next cycle; new_game and move_valid in the same cycle -> move not accepted.
